// File: rtl/and3_gate_pkg.sv
// Shared defaults and helpers for the three-input AND block.
// Counter widths above 64 are not supported by the helper.
package and3_gate_pkg;

  localparam int WIDTH_DEF = 1;
  localparam int CNT_W_DEF = 16;

  // Saturating increment: holds at max_val instead of wrapping.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input logic [63:0] max_val);
    logic [63:0] res;
    if (val >= max_val) begin
      res = max_val;
    end else begin
      res = val + 64'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/and3_sat_counter.sv
// Saturating event counter; counts clock edges where inc is high.
// Clears asynchronously on rst_n low.
module and3_sat_counter
  import and3_gate_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // For CNT_W == 64 the shift yields zero, so the subtraction gives all ones.
  localparam logic [63:0] CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_cnt_next = CNT_W'(sat_inc(64'(r_cnt), CNT_MAX));

  // Count register, held when inc is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= w_cnt_next;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/and3_gate.sv
// Bitwise three-input AND with registered copy, rising-edge detect,
// all-ones flag and a saturating count of all-ones cycles.
module and3_gate
  import and3_gate_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter bit OUT_REG = 1'b0,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] v,
  output logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] z_q,
  output logic [WIDTH-1:0] rise,
  output logic             all_ones,
  output logic [CNT_W-1:0] hit_cnt
);

  logic [WIDTH-1:0] w_r;
  logic [WIDTH-1:0] r_z_q;
  logic [WIDTH-1:0] r_rise;
  logic             r_all_ones;

  assign w_r = x & y & v;

  // r_z_q doubles as the previous-r register for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_z_q      <= '0;
      r_rise     <= '0;
      r_all_ones <= 1'b0;
    end else begin
      r_z_q      <= w_r;
      r_rise     <= w_r & ~r_z_q;
      r_all_ones <= &w_r;
    end
  end

  and3_sat_counter #(
    .CNT_W(CNT_W)
  ) u_hit_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (r_all_ones),
    .cnt  (hit_cnt)
  );

  generate
    if (OUT_REG) begin : g_z_reg
      assign z = r_z_q;
    end else begin : g_z_comb
      assign z = w_r;
    end
  endgenerate

  assign z_q      = r_z_q;
  assign rise     = r_rise;
  assign all_ones = r_all_ones;

endmodule

// File: tb/tb_and3_gate.sv
// Directed plus randomized bench for and3_gate across four parameter sets,
// with a history-based reference model for the randomized instance.
module tb_and3_gate;

  logic clk;
  logic rst_n;

  // A: WIDTH=1, OUT_REG=0, CNT_W=16
  logic a_x, a_y, a_v, a_z, a_zq, a_rise, a_all;
  logic [15:0] a_cnt;
  // B: WIDTH=1, OUT_REG=1, CNT_W=2
  logic b_x, b_y, b_v, b_z, b_zq, b_rise, b_all;
  logic [1:0] b_cnt;
  // C: WIDTH=4, OUT_REG=0, CNT_W=16
  logic [3:0] c_x, c_y, c_v, c_z, c_zq, c_rise;
  logic c_all;
  logic [15:0] c_cnt;
  // D: WIDTH=8, OUT_REG=1, CNT_W=3, randomized
  logic [7:0] d_x, d_y, d_v, d_z, d_zq, d_rise;
  logic d_all;
  logic [2:0] d_cnt;

  int vectors;
  int miscompares;

  logic [7:0] hist[$];

  and3_gate #(.WIDTH(1), .OUT_REG(1'b0), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .x(a_x), .y(a_y), .v(a_v), .z(a_z), .z_q(a_zq),
    .rise(a_rise), .all_ones(a_all), .hit_cnt(a_cnt));
  and3_gate #(.WIDTH(1), .OUT_REG(1'b1), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .x(b_x), .y(b_y), .v(b_v), .z(b_z), .z_q(b_zq),
    .rise(b_rise), .all_ones(b_all), .hit_cnt(b_cnt));
  and3_gate #(.WIDTH(4), .OUT_REG(1'b0), .CNT_W(16)) u_c (
    .clk(clk), .rst_n(rst_n), .x(c_x), .y(c_y), .v(c_v), .z(c_z), .z_q(c_zq),
    .rise(c_rise), .all_ones(c_all), .hit_cnt(c_cnt));
  and3_gate #(.WIDTH(8), .OUT_REG(1'b1), .CNT_W(3)) u_d (
    .clk(clk), .rst_n(rst_n), .x(d_x), .y(d_y), .v(d_v), .z(d_z), .z_q(d_zq),
    .rise(d_rise), .all_ones(d_all), .hit_cnt(d_cnt));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference history: the AND result sampled at every edge since reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist.delete();
    else hist.push_back(d_x & d_y & d_v);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_d();
    int n;
    int cnt;
    logic [7:0] last;
    logic [7:0] prev;
    n = hist.size();
    last = (n > 0) ? hist[n-1] : 8'h00;
    prev = (n > 1) ? hist[n-2] : 8'h00;
    cnt = 0;
    for (int j = 0; j < n - 1; j++) if (hist[j] == 8'hFF) cnt++;
    if (cnt > 7) cnt = 7;
    chk("d_z", 64'(d_z), 64'(last));
    chk("d_zq", 64'(d_zq), 64'(last));
    chk("d_rise", 64'(d_rise), 64'(last & ~prev));
    chk("d_all", 64'(d_all), 64'(last == 8'hFF));
    chk("d_cnt", 64'(d_cnt), 64'(cnt));
  endtask

  logic [2:0] seq1[6];
  logic       exp1[6];
  int         exp_cnt;

  initial begin
    vectors = 0;
    miscompares = 0;
    seq1 = '{3'b000, 3'b100, 3'b110, 3'b111, 3'b101, 3'b100};
    exp1 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    rst_n = 1'b1;
    {a_x, a_y, a_v} = 3'b000;
    {b_x, b_y, b_v} = 3'b000;
    c_x = 4'h0; c_y = 4'h0; c_v = 4'h0;
    d_x = 8'h00; d_y = 8'h00; d_v = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_a_zq", 64'(a_zq), 64'd0);
    chk("rst_a_all", 64'(a_all), 64'd0);
    chk("rst_a_cnt", 64'(a_cnt), 64'd0);
    chk("rst_c_rise", 64'(c_rise), 64'd0);
    chk("rst_d_cnt", 64'(d_cnt), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Combinational sequence on A, plus registered copy after each edge.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      {a_x, a_y, a_v} = seq1[i];
      #1 chk("a_z_seq", 64'(a_z), 64'(exp1[i]));
      @(posedge clk);
      #1 chk("a_zq_seq", 64'(a_zq), 64'(exp1[i]));
    end

    // Unknown inputs between edges: 0 dominates, otherwise X propagates.
    @(negedge clk);
    a_x = 1'b0; a_y = 1'bx; a_v = 1'b1;
    #1 chk("a_z_x0", 64'(a_z), 64'd0);
    a_x = 1'b1;
    #1 chk("a_z_xx", 64'(a_z), {63'd0, 1'bx});
    {a_x, a_y, a_v} = 3'b000;

    // B: registered z, rise pulse, all_ones, saturation at 3.
    @(negedge clk);
    {b_x, b_y, b_v} = 3'b111;
    #1 chk("b_z_pre", 64'(b_z), 64'd0);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      chk("b_z", 64'(b_z), 64'd1);
      chk("b_rise", 64'(b_rise), (k == 1) ? 64'd1 : 64'd0);
      chk("b_all", 64'(b_all), 64'd1);
      chk("b_cnt", 64'(b_cnt), (k - 1 > 3) ? 64'd3 : 64'(k - 1));
    end

    // C: multi-bit AND.
    @(negedge clk);
    c_x = 4'b1111; c_y = 4'b1010; c_v = 4'b0110;
    #1 chk("c_z", 64'(c_z), 64'h2);
    @(posedge clk);
    #1;
    chk("c_zq", 64'(c_zq), 64'h2);
    chk("c_all0", 64'(c_all), 64'd0);
    chk("c_rise0", 64'(c_rise), 64'h2);
    @(negedge clk);
    c_y = 4'b1111; c_v = 4'b1111;
    @(posedge clk);
    #1;
    chk("c_all1", 64'(c_all), 64'd1);
    chk("c_rise1", 64'(c_rise), 64'hD);

    // D: randomized against history model; all-ones forced often enough to saturate.
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        d_x = 8'hFF; d_y = 8'hFF; d_v = 8'hFF;
      end else begin
        d_x = 8'($urandom) | 8'($urandom);
        d_y = 8'($urandom) | 8'($urandom);
        d_v = 8'($urandom) | 8'($urandom);
      end
      @(posedge clk);
      #1 chk_d();
    end

    // A: build hit_cnt to 5, then reset mid-cycle.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    {a_x, a_y, a_v} = 3'b111;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      exp_cnt = k - 1;
      chk("a_cnt_up", 64'(a_cnt), 64'(exp_cnt));
    end
    #4 rst_n = 1'b0;
    #1;
    chk("mr_a_cnt", 64'(a_cnt), 64'd0);
    chk("mr_a_zq", 64'(a_zq), 64'd0);
    chk("mr_a_rise", 64'(a_rise), 64'd0);
    chk("mr_a_all", 64'(a_all), 64'd0);
    chk("mr_a_z1", 64'(a_z), 64'd1);
    chk("mr_b_cnt", 64'(b_cnt), 64'd0);
    chk("mr_d_zq", 64'(d_zq), 64'd0);
    a_x = 1'b0;
    #1 chk("mr_a_z0", 64'(a_z), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/and3_gate.md
AND3_GATE -- requirements
Module: and3_gate

Interface
REQ-001 Parameter WIDTH, default 1: bit width of every data input and output; legal range 1..64.
REQ-002 Parameter OUT_REG, default 0: 0 selects a combinational z; 1 selects z taken from the output register.
REQ-003 Parameter CNT_W, default 16: width of the assertion counter.
REQ-004 One clock and one reset; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all registered state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 x  input  WIDTH  first AND operand.
REQ-008 y  input  WIDTH  second AND operand.
REQ-009 v  input  WIDTH  third AND operand.
REQ-010 z  output  WIDTH  bitwise x & y & v, combinational or registered per OUT_REG.
REQ-011 z_q  output  WIDTH  registered copy of x & y & v.
REQ-012 rise  output  WIDTH  one-cycle per-bit pulse when a bit of the AND result goes 0->1 between consecutive clock edges.
REQ-013 all_ones  output  1  registered flag; high when every bit of the AND result is 1.
REQ-014 hit_cnt  output  CNT_W  count of cycles with all_ones set.

Function
REQ-015 The AND result r SHALL be defined as r = x & y & v, bitwise, with no reduction across bits.
REQ-016 With OUT_REG=0, z SHALL equal r combinationally, with zero clock latency and no dependence on clk or rst_n.
REQ-017 With OUT_REG=1, z SHALL equal z_q, giving one cycle of latency.
REQ-018 z_q SHALL load r on every rising clk edge.
REQ-019 rise[i] SHALL be 1 for exactly one cycle when r[i] was 0 at the previous edge and is 1 at the current edge; otherwise 0.
REQ-020 all_ones SHALL load (&r) on every rising edge.
REQ-021 hit_cnt SHALL increment by 1 on each edge where all_ones is 1.
REQ-022 hit_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-023 An X or Z on any input SHALL propagate to z under normal Verilog AND semantics (0 dominates).
REQ-024 Simultaneous input changes SHALL produce no intermediate registered values; only the value sampled at the edge matters.

Reset
REQ-025 While rst_n=0, z_q, rise, all_ones and hit_cnt SHALL be 0, asynchronously.
REQ-026 While rst_n=0, the internal previous-r register SHALL be 0, so the first post-reset edge with r[i]=1 asserts rise[i].
REQ-027 A reset asserted mid-count SHALL clear hit_cnt immediately.
REQ-028 With OUT_REG=0, z SHALL remain live and unaffected during reset.
REQ-029 Reset deassertion SHALL be taken synchronously to clk by the integrator; the block contains no synchronizer.

Structure
REQ-030 A shared package and3_gate_pkg SHALL hold the WIDTH/CNT_W defaults and a saturating-increment function.
REQ-031 One sub-module, and3_sat_counter (parameter CNT_W; ports clk, rst_n, inc, cnt), SHALL implement hit_cnt.
REQ-032 All other logic SHALL be inline in and3_gate.

Verification
REQ-033 The bench SHALL cover this stepped sequence with WIDTH=1, OUT_REG=0, 20 ns per step: xyv=000, 100, 110, 111, 101, 100 -> z = 0,0,0,1,0,0.
REQ-034 The bench SHALL cover: OUT_REG=1, xyv=111 applied before an edge -> z=0 until that edge, then z=1; rise=1 for one cycle; all_ones=1.
REQ-035 The bench SHALL cover: WIDTH=4, x=4'b1111, y=4'b1010, v=4'b0110 -> z=4'b0010, all_ones=0.
REQ-036 The bench SHALL cover: CNT_W=2, xyv=111 held for 6 cycles -> hit_cnt reaches 3 and stays at 3.
REQ-037 The bench SHALL cover: rst_n pulled low mid-cycle with hit_cnt=5 -> hit_cnt, z_q, rise and all_ones drop to 0 immediately, and z (OUT_REG=0) still follows r.
